// File: rtl/dmem_ctrl_pkg.sv
// Shared RV32 definitions used by the data-memory controller:
// opcode and funct3 encodings plus the access alignment rule.
package dmem_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    // Byte accesses are always aligned, halfwords need an even address,
    // everything else is treated as a full word.
    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            FUNCT3_B, FUNCT3_BU: is_aligned = 1'b1;
            FUNCT3_H, FUNCT3_HU: is_aligned = (off[0] == 1'b0);
            default:             is_aligned = (off == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// RAM-side request/acknowledge bus between the controller and the data RAM.
interface dmem_ctrl_if;

    logic        ram_req_out;
    logic        ram_we_out;
    logic [3:0]  ram_be_out;
    logic [31:0] ram_addr_out;
    logic [31:0] ram_wdata_out;
    logic        ram_ack_in;
    logic [31:0] ram_rdata_in;

    modport master (
        output ram_req_out, ram_we_out, ram_be_out, ram_addr_out, ram_wdata_out,
        input  ram_ack_in, ram_rdata_in
    );

    modport slave (
        input  ram_req_out, ram_we_out, ram_be_out, ram_addr_out, ram_wdata_out,
        output ram_ack_in, ram_rdata_in
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte enables and data replication,
// and right-justification of the returned load word.
module dmem_lane_align
    import dmem_ctrl_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] wdata,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] st_data,
    output logic [31:0] ld_data
);

    // Select enables and replicate narrow store data across the word.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        be      = 4'b1111;
        st_data = wdata;
        if (is_store) begin
            case (funct3)
                FUNCT3_B: begin
                    be      = 4'b0001 << st_off;
                    st_data = {4{wdata[7:0]}};
                end
                FUNCT3_H: begin
                    be      = 4'b0011 << st_off;
                    st_data = {2{wdata[15:0]}};
                end
                default: ;
            endcase
        end
        ld_data = rdata >> {ld_off, 3'b000};
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller for the RV32 memory stage: stalls the pipeline,
// issues one registered RAM request per load/store and reports misaligned
// accesses and RAM timeouts as single-cycle pulses.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic [6:0]         opcode_in,
    input  logic [2:0]         funct3_in,
    input  logic [31:0]        addr_in,
    input  logic [31:0]        wdata_in,
    output logic               stall_out,
    output logic [31:0]        ram_data_out,
    output logic               misalign_out,
    output logic               timeout_out,
    dmem_ctrl_if.master        bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       ld_off_q;
    logic             is_load_q;

    logic        is_store, is_access, aligned, start, misalign;
    logic        ack_ok, expire;
    logic [3:0]  be;
    logic [31:0] st_data, ld_data;

    assign is_store  = (opcode_in == OPC_STORE);
    assign is_access = valid_in && ((opcode_in == OPC_LOAD) || is_store);
    assign aligned   = is_aligned(funct3_in, addr_in[1:0]);
    assign start     = is_access && aligned;
    assign misalign  = is_access && !aligned;

    dmem_lane_align u_align (
        .is_store (is_store),
        .funct3   (funct3_in),
        .st_off   (addr_in[1:0]),
        .wdata    (wdata_in),
        .ld_off   (ld_off_q),
        .rdata    (bus.ram_rdata_in),
        .be       (be),
        .st_data  (st_data),
        .ld_data  (ld_data)
    );

    // Next-state, stall and completion decode; ack only counts in ACCESS,
    // and a late ack wins over an expiring counter.
    always_comb begin
        state_d   = state_q;
        stall_out = 1'b0;
        ack_ok    = 1'b0;
        expire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    stall_out = 1'b1;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                stall_out = 1'b1;
                if (bus.ram_ack_in) begin
                    ack_ok  = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    expire  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Registered RAM bus, timeout counter, load result and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q             <= '0;
            ld_off_q          <= 2'b00;
            is_load_q         <= 1'b0;
            bus.ram_req_out   <= 1'b0;
            bus.ram_we_out    <= 1'b0;
            bus.ram_be_out    <= 4'b0000;
            bus.ram_addr_out  <= 32'h0;
            bus.ram_wdata_out <= 32'h0;
            ram_data_out      <= 32'h0;
            misalign_out      <= 1'b0;
            timeout_out       <= 1'b0;
        end else begin
            misalign_out <= (state_q == IDLE) && misalign;
            timeout_out  <= expire;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (start) begin
                        bus.ram_req_out   <= 1'b1;
                        bus.ram_we_out    <= is_store;
                        bus.ram_be_out    <= be;
                        bus.ram_addr_out  <= {addr_in[31:2], 2'b00};
                        bus.ram_wdata_out <= st_data;
                        ld_off_q          <= addr_in[1:0];
                        is_load_q         <= !is_store;
                    end
                    if (misalign) ram_data_out <= 32'h0;
                end
                ACCESS: begin
                    if (ack_ok) begin
                        bus.ram_req_out <= 1'b0;
                        if (is_load_q) ram_data_out <= ld_data;
                    end else if (expire) begin
                        bus.ram_req_out <= 1'b0;
                        ram_data_out    <= 32'h0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
